register_output_bank: RTL

REGISTER_OUTPUT_BANK -- requirements
Module: register_output_bank

---
 rtl/register_output_bank.sv | 125 ++++++++++++
 1 files changed

// File: rtl/register_output_bank.sv
// register_output_bank
//
// A bank of NCH output registers, each Psize bits wide. A write into a channel
// happens only when the ALU qualifier is all-ones and the channel select is in
// range. Each channel holds a pending flag that stays set until its consumer
// acknowledges with OutReady. A write that replaces unacknowledged data can
// optionally raise a sticky per-channel overflow flag.
//
// Optional feature macro: REGOUT_OVERFLOW_EN
//   defined   : Overflow tracks overwrite-before-ack events; ClrOvf clears it.
//   undefined : Overflow is constant 0 and ClrOvf is ignored.
//
// Parameters
//   Psize : data width of each channel
//   NCH   : number of channels (1..16)
//   SELW  : channel-select width, derived from NCH
//
// Ports
//   clk      : clock; all state updates on its rising edge
//   Reset    : synchronous active-high reset
//   RegIn    : data to write
//   ALURes   : write qualifier; must be all-ones to write
//   ChSel    : target channel for a write
//   RegOut   : channel k data in bits [k*Psize +: Psize]
//   OutValid : per-channel pending-data flag
//   OutReady : per-channel consumer acknowledge
//   Overflow : per-channel sticky overwrite-before-ack flag
//   ClrOvf   : clears all Overflow bits
module register_output_bank #(
    parameter int unsigned Psize = 8,
    parameter int unsigned NCH   = 4,
    localparam int unsigned SELW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 Reset,
    input  logic [Psize-1:0]     RegIn,
    input  logic [Psize-1:0]     ALURes,
    input  logic [SELW-1:0]      ChSel,
    output logic [NCH*Psize-1:0] RegOut,
    output logic [NCH-1:0]       OutValid,
    input  logic [NCH-1:0]       OutReady,
    output logic [NCH-1:0]       Overflow,
    input  logic                 ClrOvf
);

    typedef enum logic {StIdle, StPend} ch_state_e;

    ch_state_e        state_q [NCH];
    ch_state_e        state_d [NCH];
    logic [Psize-1:0] data_q  [NCH];
    logic [Psize-1:0] data_d  [NCH];
    logic [NCH-1:0]   ovf_set;
    logic             commit;

    // An out-of-range select never writes, even with a qualifying ALU result.
    assign commit = (ALURes == {Psize{1'b1}}) &&
                    ({{(32 - SELW){1'b0}}, ChSel} < 32'(NCH));

    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            state_d[k] = state_q[k];
            data_d[k]  = data_q[k];
            ovf_set[k] = 1'b0;
            unique case (state_q[k])
                StIdle: begin
                    if (commit && (ChSel == SELW'(k))) begin
                        data_d[k]  = RegIn;
                        state_d[k] = StPend;
                    end
                end
                StPend: begin
                    if (commit && (ChSel == SELW'(k))) begin
                        // Latest data wins; an ack in the same cycle consumes the old data.
                        data_d[k]  = RegIn;
                        ovf_set[k] = ~OutReady[k];
                    end else if (OutReady[k]) begin
                        state_d[k] = StIdle;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < NCH; k++) begin
            if (Reset) begin
                state_q[k] <= StIdle;
                data_q[k]  <= '0;
            end else begin
                state_q[k] <= state_d[k];
                data_q[k]  <= data_d[k];
            end
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_out
        assign RegOut[k*Psize +: Psize] = data_q[k];
        assign OutValid[k]              = (state_q[k] == StPend);
    end

`ifdef REGOUT_OVERFLOW_EN
    logic [NCH-1:0] ovf_q;
    logic [NCH-1:0] ovf_d;

    // A new overflow event in the same cycle as ClrOvf takes priority.
    always_comb begin
        ovf_d = (ovf_q & ~{NCH{ClrOvf}}) | ovf_set;
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign Overflow = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = ClrOvf ^ (|ovf_set);
    assign Overflow   = '0;
`endif

endmodule
